// File: rtl/psram_req_arbiter.sv
// Round-robin arbiter sharing one PSRAM transaction engine among NUM_REQ requesters.
// Optional watchdog abort in WAIT is enabled by defining PSRAM_ARB_WDOG_EN.
module psram_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_CYC    = 2,
  parameter int WDOG_CYC   = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0]              req_wr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
  output logic                            cmd_valid_o,
  input  logic                            cmd_ready_i,
  output logic                            cmd_wr_o,
  output logic [ADDR_WIDTH-1:0]           cmd_addr_o,
  output logic [LEN_WIDTH-1:0]            cmd_len_o,
  output logic [$clog2(NUM_REQ)-1:0]      cmd_id_o,
  input  logic                            cmd_done_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            busy_o,
  output logic                            err_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]            state_reg;
  logic [IDW-1:0]        rr_ptr_reg;
  logic [IDW-1:0]        id_reg;
  logic [GCW-1:0]        gap_cnt_reg;
  logic                  wr_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [NUM_REQ-1:0]    grant_reg;

  logic [ADDR_WIDTH-1:0] port_addr [NUM_REQ];
  logic [LEN_WIDTH-1:0]  port_len  [NUM_REQ];
  logic [NUM_REQ-1:0]    pick_onehot;
  logic [NUM_REQ-1:0]    id_onehot;
  logic [IDW-1:0]        pick_id;
  logic                  pick_found;
  logic [IDW-1:0]        ptr_after_id;
  logic                  handshake;
  logic                  wdog_trip;
  logic                  done_evt;
  logic                  arb_now;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign port_addr[gi]   = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign port_len[gi]    = req_len_i[gi*LEN_WIDTH +: LEN_WIDTH];
      assign pick_onehot[gi] = (pick_id == IDW'(gi));
      assign id_onehot[gi]   = (id_reg == IDW'(gi));
      assign req_ready_o[gi] = handshake & id_onehot[gi];
    end
  endgenerate

  // Scan downward so the candidate closest to rr_ptr (offset 0) is assigned last and wins.
  always_comb begin
    int             sum;
    logic [IDW-1:0] idx;
    pick_found = 1'b0;
    pick_id    = '0;
    sum        = 0;
    idx        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = int'(rr_ptr_reg) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IDW'(sum);
      if (req_valid_i[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign ptr_after_id = (int'(id_reg) == NUM_REQ - 1) ? '0 : id_reg + 1'b1;
  assign handshake    = (state_reg == ST_ISSUE) && cmd_ready_i;
  assign done_evt     = (state_reg == ST_WAIT) && (cmd_done_i || wdog_trip);
  // The final GAP cycle doubles as the arbitration slot so the gap is exactly GAP_CYC cycles.
  assign arb_now      = (state_reg == ST_IDLE)
                     || ((state_reg == ST_GAP) && (gap_cnt_reg == '0))
                     || ((GAP_CYC == 0) && done_evt);

`ifdef PSRAM_ARB_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wdog_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_cnt_reg <= '0;
    end else if (state_reg != ST_WAIT) begin
      wdog_cnt_reg <= '0;
    end else begin
      wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
    end
  end

  assign wdog_trip = (state_reg == ST_WAIT) && !cmd_done_i
                  && (wdog_cnt_reg == WDW'(WDOG_CYC - 1));
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYC == 0);
  assign wdog_trip   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      rr_ptr_reg  <= '0;
      id_reg      <= '0;
      gap_cnt_reg <= '0;
      wr_reg      <= 1'b0;
      addr_reg    <= '0;
      len_reg     <= '0;
      grant_reg   <= '0;
    end else if (handshake) begin
      state_reg  <= ST_WAIT;
      rr_ptr_reg <= ptr_after_id;
    end else if (done_evt && (GAP_CYC != 0)) begin
      state_reg   <= ST_GAP;
      gap_cnt_reg <= GCW'(GAP_CYC - 1);
      grant_reg   <= '0;
    end else if (arb_now) begin
      if (pick_found) begin
        state_reg <= ST_ISSUE;
        id_reg    <= pick_id;
        wr_reg    <= req_wr_i[pick_id];
        addr_reg  <= port_addr[pick_id];
        len_reg   <= port_len[pick_id];
        grant_reg <= pick_onehot;
      end else begin
        state_reg <= ST_IDLE;
        grant_reg <= '0;
      end
    end else if (state_reg == ST_GAP) begin
      gap_cnt_reg <= gap_cnt_reg - 1'b1;
    end
  end

  assign cmd_valid_o = (state_reg == ST_ISSUE);
  assign cmd_wr_o    = wr_reg;
  assign cmd_addr_o  = addr_reg;
  assign cmd_len_o   = len_reg;
  assign cmd_id_o    = id_reg;
  assign grant_o     = grant_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign err_o       = wdog_trip;

endmodule
